// File: rtl/block_expand.sv
// Block-floating-point expander: applies a per-frame left-shift exponent to each sample
// and reduces to OUT_W bits. Define BLOCK_EXPAND_SAT_EN to saturate instead of wrap.
module block_expand #(
   parameter int IN_W      = 10,
   parameter int OUT_W     = 16,
   parameter int EXP_W     = 3,
   parameter int FRAME_LEN = 16
) (
   input  logic                    mclk,
   input  logic                    i_rst_n,
   input  logic                    i_vld,
   input  logic                    i_sof,
   input  logic [EXP_W-1:0]        i_exp,
   input  logic signed [IN_W-1:0]  i_data,
   output logic                    o_vld,
   output logic                    o_sof,
   output logic signed [OUT_W-1:0] o_data,
   output logic                    o_ovf,
   output logic                    o_err
);

   localparam int CNT_W = $clog2(FRAME_LEN);

   typedef enum logic {IDLE, RUN} state_e;

   state_e                   state_q;
   logic [CNT_W-1:0]         cnt_q;
   logic [EXP_W-1:0]         exp_q;

   logic                     s1_vld_q;
   logic                     s1_sof_q;
   logic                     s1_err_q;
   logic signed [IN_W-1:0]   s1_data_q;
   logic [EXP_W-1:0]         s1_shf_q;

   logic                     o_vld_q;
   logic                     o_sof_q;
   logic signed [OUT_W-1:0]  o_data_q;
   logic                     o_ovf_q;
   logic                     o_err_q;

   logic                     accept_d;
   logic                     err_d;
   logic [EXP_W-1:0]         shf_d;
   logic signed [OUT_W-1:0]  res_d;
   logic                     ovf_d;

   // A sof always restarts a frame; a non-sof sample is only legal inside a frame.
   always_comb begin
      accept_d = i_vld & (i_sof | (state_q == RUN));
      err_d    = i_vld & (i_sof == (state_q == RUN));
      shf_d    = i_sof ? i_exp : exp_q;
   end

`ifdef BLOCK_EXPAND_SAT_EN
   localparam int WIDE_W = IN_W + (2 ** EXP_W) - 1;
   localparam int EXT_W  = (WIDE_W > OUT_W) ? WIDE_W : OUT_W;
   localparam logic signed [EXT_W-1:0] MAX_V = {{(EXT_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
   localparam logic signed [EXT_W-1:0] MIN_V = {{(EXT_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

   logic signed [EXT_W-1:0] wide;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      wide  = EXT_W'(s1_data_q) <<< s1_shf_q;
      res_d = wide[OUT_W-1:0];
      ovf_d = 1'b0;
      if (wide > MAX_V) begin
         res_d = {1'b0, {(OUT_W-1){1'b1}}};
         ovf_d = 1'b1;
      end else if (wide < MIN_V) begin
         res_d = {1'b1, {(OUT_W-1){1'b0}}};
         ovf_d = 1'b1;
      end
   end
`else
   // Shifting at OUT_W width yields exactly the low OUT_W bits of the full-width result.
   always_comb begin
      res_d = OUT_W'(s1_data_q) <<< s1_shf_q;
      ovf_d = 1'b0;
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge mclk) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         exp_q     <= '0;
         s1_vld_q  <= 1'b0;
         s1_sof_q  <= 1'b0;
         s1_err_q  <= 1'b0;
         s1_data_q <= '0;
         s1_shf_q  <= '0;
         o_vld_q   <= 1'b0;
         o_sof_q   <= 1'b0;
         o_data_q  <= '0;
         o_ovf_q   <= 1'b0;
         o_err_q   <= 1'b0;
      end else begin
         if (i_vld) begin
            if (i_sof) begin
               state_q <= RUN;
               cnt_q   <= CNT_W'(1);
               exp_q   <= i_exp;
            end else if (state_q == RUN) begin
               if (cnt_q == CNT_W'(FRAME_LEN - 1)) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
         end

         s1_vld_q  <= accept_d;
         s1_sof_q  <= i_vld & i_sof;
         s1_err_q  <= err_d;
         s1_data_q <= i_data;
         s1_shf_q  <= shf_d;

         o_vld_q <= s1_vld_q;
         o_sof_q <= s1_vld_q & s1_sof_q;
         o_ovf_q <= s1_vld_q & ovf_d;
         o_err_q <= s1_err_q;
         if (s1_vld_q) begin
            o_data_q <= res_d;
         end
      end
   end

   assign o_vld  = o_vld_q;
   assign o_sof  = o_sof_q;
   assign o_data = o_data_q;
   assign o_ovf  = o_ovf_q;
   assign o_err  = o_err_q;

endmodule
